// File: rtl/sdf_var_delay_line.sv
// Runtime-selectable complex delay line for SDF FFT stages: ring buffer plus
// one output register, with enable gating, flush and illegal-depth detection.
module sdf_var_delay_line #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic [ADDR_WIDTH:0]   depth,
  input  logic [DATA_WIDTH-1:0] data_in_r,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  output logic [DATA_WIDTH-1:0] data_out_r,
  output logic [DATA_WIDTH-1:0] data_out_i,
  output logic                  out_valid,
  output logic                  depth_err
);

  localparam int MAX_DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MAX_D = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef struct packed {
    logic [DATA_WIDTH-1:0] r;
    logic [DATA_WIDTH-1:0] i;
  } cplx_t;

  cplx_t                 mem [MAX_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic [ADDR_WIDTH:0]   depth_q;

  logic                  illegal;
  logic [ADDR_WIDTH:0]   dc;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] rd_addr;
  cplx_t                 din;

  assign din     = '{r: data_in_r, i: data_in_i};
  assign illegal = (depth == '0) || (depth > MAX_D);

  always_comb begin
    dc = depth;
    if (depth == '0)        dc = {{ADDR_WIDTH{1'b0}}, 1'b1};
    else if (depth > MAX_D) dc = MAX_D;
  end

  // A pending reconfiguration or flush swallows the sample, so the ring is
  // only written on a true accept.
  assign accept  = rst && !flush && (dc == depth_q) && en;
  // D-1 back from the write slot; depth_q-1 never exceeds MAX_DEPTH-1.
  assign rd_addr = wr_ptr - ADDR_WIDTH'(depth_q - 1'b1);

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out_r <= '0;
      data_out_i <= '0;
      out_valid  <= 1'b0;
      depth_err  <= 1'b0;
      wr_ptr     <= '0;
      cnt        <= '0;
      depth_q    <= dc;
    end else begin
      depth_err <= illegal;
      if (flush) begin
        data_out_r <= '0;
        data_out_i <= '0;
        out_valid  <= 1'b0;
        wr_ptr     <= '0;
        cnt        <= '0;
        depth_q    <= dc;
      end else if (dc != depth_q) begin
        data_out_r <= '0;
        data_out_i <= '0;
        out_valid  <= 1'b0;
        cnt        <= '0;
        depth_q    <= dc;
      end else if (en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (cnt != MAX_D) cnt <= cnt + 1'b1;
        if (cnt >= depth_q - 1'b1) begin
          out_valid <= 1'b1;
          if (depth_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
            data_out_r <= din.r;
            data_out_i <= din.i;
          end else begin
            data_out_r <= mem[rd_addr].r;
            data_out_i <= mem[rd_addr].i;
          end
        end else begin
          data_out_r <= '0;
          data_out_i <= '0;
          out_valid  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdf_var_delay_line.sv
// Directed bench for sdf_var_delay_line: a history-based reference model pushes
// the expected {valid, err, re, im} per edge; each is popped after the edge.
module tb_sdf_var_delay_line;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int MAXD = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic [AW:0]   depth = '0;
  logic [DW-1:0] data_in_r = '0;
  logic [DW-1:0] data_in_i = '0;
  logic [DW-1:0] data_out_r;
  logic [DW-1:0] data_out_i;
  logic          out_valid;
  logic          depth_err;

  sdf_var_delay_line #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .depth(depth),
    .data_in_r(data_in_r), .data_in_i(data_in_i),
    .data_out_r(data_out_r), .data_out_i(data_out_i),
    .out_valid(out_valid), .depth_err(depth_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // reference model state
  logic [2*DW-1:0]   hist[$];
  logic [2*DW+1:0]   exp_q[$];
  logic [2*DW-1:0]   m_out = '0;
  bit                m_v = 1'b0;
  int                m_dq = 0;

  task automatic check(input string tag, input logic [2*DW+1:0] o, input logic [2*DW+1:0] e);
    checks++;
    assert (o === e) passed++;
    else $error("FAIL %s obs=%h exp=%h", tag, o, e);
  endtask

  function automatic logic [2*DW+1:0] observed();
    return {out_valid, depth_err, data_out_r, data_out_i};
  endfunction

  task automatic step(input bit rv, input bit ev, input bit fv, input int dep,
                      input logic [DW-1:0] r, input logic [DW-1:0] i, input string tag);
    int dc;
    bit err;
    rst = rv; en = ev; flush = fv; depth = (AW+1)'(dep);
    data_in_r = r; data_in_i = i;
    err = (dep == 0) || (dep > MAXD);
    dc  = (dep == 0) ? 1 : ((dep > MAXD) ? MAXD : dep);
    if (!rv) begin
      err = 1'b0; m_out = '0; m_v = 1'b0; hist.delete(); m_dq = dc;
    end else if (fv || dc != m_dq) begin
      m_out = '0; m_v = 1'b0; hist.delete(); m_dq = dc;
    end else if (ev) begin
      hist.push_back({r, i});
      if (hist.size() > MAXD) void'(hist.pop_front());
      if (hist.size() >= m_dq) begin
        m_out = hist[hist.size() - m_dq]; m_v = 1'b1;
      end else begin
        m_out = '0; m_v = 1'b0;
      end
    end
    exp_q.push_back({m_v, err, m_out});
    @(posedge clk); #1;
    check(tag, observed(), exp_q.pop_front());
  endtask

  initial begin
    int acc;
    logic [DW-1:0] k16;

    // reset
    step(0, 0, 0, 8, '0, '0, "reset0");
    step(0, 1, 0, 8, 16'h1234, 16'h5678, "reset1");
    check("reset_state", observed(), '0);

    // depth 8, continuous accepts
    for (int k = 1; k <= 20; k++) begin
      k16 = DW'(k);
      step(1, 1, 0, 8, k16, -k16, "d8_run");
      if (k == 7) check("d8_edge7", observed(), '0);
      if (k == 8) check("d8_edge8", observed(), {2'b10, 16'd1, 16'hFFFF});
    end
    check("d8_edge20", observed(), {2'b10, 16'd13, 16'hFFF3});

    // depth 4 with en toggling; sample count advances only on accepts
    step(1, 1, 0, 4, 16'hDEAD, 16'hBEEF, "d4_reconf");
    check("d4_reconf_out", observed(), '0);
    acc = 0;
    for (int j = 0; j < 16; j++) begin
      if (j % 2 == 0) begin
        acc++;
        k16 = DW'(acc);
        step(1, 1, 0, 4, k16, -k16, "d4_acc");
        if (acc == 3) check("d4_acc3", observed(), '0);
        if (acc == 4) check("d4_acc4", observed(), {2'b10, 16'd1, 16'hFFFF});
      end else begin
        step(1, 0, 0, 4, 16'hAAAA, 16'h5555, "d4_hold");
        if (acc == 4) check("d4_hold4", observed(), {2'b10, 16'd1, 16'hFFFF});
      end
    end

    // depth 1 bypass
    step(1, 1, 0, 1, 16'h0BAD, 16'h0BAD, "d1_reconf");
    step(1, 1, 0, 1, 16'h1111, 16'h2222, "d1_run");
    check("d1_first", observed(), {2'b10, 16'h1111, 16'h2222});
    for (int j = 0; j < 6; j++)
      step(1, 1, 0, 1, DW'($urandom), DW'($urandom), "d1_run");

    // depth 64, three wraps
    step(1, 1, 0, 64, 16'h0BAD, 16'h0BAD, "d64_reconf");
    for (int k = 1; k <= 200; k++) begin
      k16 = DW'(k);
      step(1, 1, 0, 64, k16, ~k16, "d64_run");
      if (k == 63) check("d64_k63", observed(), '0);
    end
    check("d64_k200", observed(), {2'b10, 16'd137, ~16'd137});

    // depth 8 then switch to 3 mid-stream
    step(1, 1, 0, 8, 16'h0BAD, 16'h0BAD, "d8b_reconf");
    for (int k = 1; k <= 12; k++) step(1, 1, 0, 8, DW'(k + 300), DW'(k), "d8b_run");
    step(1, 1, 0, 3, 16'h7777, 16'h7777, "d3_switch");
    check("d3_switch_out", observed(), '0);
    for (int k = 1; k <= 6; k++) begin
      step(1, 1, 0, 3, DW'(k + 500), DW'(k), "d3_run");
      if (k == 2) check("d3_acc2", observed(), '0);
      if (k == 3) check("d3_acc3", observed(), {2'b10, 16'd501, 16'd1});
    end

    // illegal depth 0 behaves as D=1
    for (int k = 1; k <= 4; k++) step(1, 1, 0, 0, DW'(k + 40), DW'(k), "d0_run");
    check("d0_err", observed(), {2'b11, 16'd44, 16'd4});

    // flush with out-of-range depth
    step(1, 1, 1, 100, 16'h0BAD, 16'h0BAD, "flush100");
    check("flush100_out", observed(), {2'b01, 32'd0});
    for (int k = 1; k <= 70; k++) step(1, 1, 0, 100, DW'(k), DW'(k + 1000), "d100_run");
    check("d100_k70", observed(), {2'b11, 16'd7, 16'd1007});

    // reset mid-stream
    step(0, 1, 0, 5, 16'h0BAD, 16'h0BAD, "rst_mid");
    check("rst_mid_out", observed(), '0);

    // mixed en / flush traffic at depth 5
    for (int j = 0; j < 80; j++)
      step(1, bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 19) == 0), 5,
           DW'($urandom), DW'($urandom), "mix");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sdf_var_delay_line.md
Name: sdf_var_delay_line

Overview:
- Parametrised complex (real/imag) delay line for the SDF FFT/IFFT pipeline stages; successor to the fixed-depth register-chain shifter.
- Delay depth is selectable at runtime (1..MAX_DEPTH), so one instance serves any stage or FFT size.
- Shifting is gated by an enable, and the block provides a primed/valid flag, flush, and illegal-depth detection.
- Storage is a register-array ring buffer plus one output register, not a chain of delay units.

Parameters:
- DATA_WIDTH, 16, width of each of the real and imaginary samples.
- ADDR_WIDTH, 6, ring address width; MAX_DEPTH = 2**ADDR_WIDTH (default 64).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  sample-accept strobe; when low, all state holds.
- flush  in  1  synchronous clear of pipeline contents (active high).
- depth  in  ADDR_WIDTH+1  requested delay D in accepted samples; legal range 1..MAX_DEPTH.
- data_in_r  in  DATA_WIDTH  real input sample.
- data_in_i  in  DATA_WIDTH  imaginary input sample.
- data_out_r  out  DATA_WIDTH  delayed real sample (registered).
- data_out_i  out  DATA_WIDTH  delayed imaginary sample (registered).
- out_valid  out  1  data_out carries a real delayed sample (not zero fill).
- depth_err  out  1  registered flag: current depth input is illegal.

Behaviour:
- Internal state:
  - mem[0:MAX_DEPTH-1] holds complex samples.
  - wr_ptr is ADDR_WIDTH bits and wraps modulo MAX_DEPTH.
  - cnt is the fill count; it saturates at MAX_DEPTH.
  - depth_q is the active delay.
- Depth clamping: Dc = 1 if depth==0; Dc = MAX_DEPTH if depth>MAX_DEPTH; otherwise Dc = depth.
- depth_err <= (depth==0 || depth>MAX_DEPTH) every non-reset cycle, regardless of en.
- Priority per edge: reset > flush > reconfiguration > en.
- Reset (rst==0 at edge):
  - data_out_r/i=0, out_valid=0, depth_err=0, wr_ptr=0, cnt=0.
  - depth_q <= Dc, so no reconfiguration cycle follows reset.
  - mem contents need not be cleared.
- Flush (rst==1, flush==1):
  - Same clearing as reset, except depth_err still updates.
  - The input sample is not accepted even if en==1.
- Reconfiguration (no flush, Dc != depth_q):
  - depth_q<=Dc, cnt<=0, wr_ptr holds, data_out<=0, out_valid<=0.
  - The sample is NOT accepted even if en==1.
- Accept (en==1, no higher-priority event):
  - The sample is written to mem[wr_ptr], then wr_ptr<=wr_ptr+1 (wraps) and cnt<=min(cnt+1, MAX_DEPTH).
  - The read uses pre-edge contents; the write happens on the same edge.
- Output on accept, with D=depth_q:
  - If cnt >= D-1 (pre-edge value): out_valid<=1 and data_out<=X.
    - X = data_in if D==1 (bypass).
    - X = mem[wr_ptr-(D-1) mod MAX_DEPTH] otherwise.
  - Else: data_out<=0, out_valid<=0.
- Latency: the n-th accepted sample appears on data_out right after the (n+D-1)-th accepting edge.
  - With en tied high this equals a D-stage shift register, i.e. D clocks.
  - The first valid output follows the D-th accepted sample.
- en==0: data_out, out_valid, wr_ptr, cnt and mem all hold; the delay counts accepted samples, not clocks.
- Wrap-around: ring addressing is modulo MAX_DEPTH. D=MAX_DEPTH reads MAX_DEPTH-1 entries back, so the write never overwrites an unread sample.
- Simultaneous flush and depth change: flush wins; depth_q loads Dc in the same cycle.
- Reset mid-stream: the output is zero on the next cycle; the next valid output needs D fresh accepts.
- No combinational path from any input to any output.

Test Plan:
1. Reset, then depth=8 with en=1 for 20 cycles and data_in_r=k, data_in_i=-k on cycle k=1.. -> data_out=0 and out_valid=0 through edge 7; after edge 8, out=(1,-1) with out_valid=1; after edge 20, out=(13,-13).
2. depth=4 with en toggling 1,0,1,0,... and samples 1,2,3,... on accepts -> output changes only on accepting edges; the first valid output is 1, right after the 4th accept; it holds while en=0.
3. depth=1 -> data_out equals the previous cycle's data_in, and out_valid=1 after the first accept.
4. depth=64 (MAX) with 200 continuous accepts -> output sample n-63 after accept n; correct across three wr_ptr wraps.
5. Running at depth=8, switch depth to 3 mid-stream -> on that edge out=0, out_valid=0 and the sample is dropped; valid resumes after 3 further accepts with the correct 3-delay.
6. Set depth=0 -> depth_err=1 and the block behaves as D=1. Then assert flush together with depth=100 -> depth_err=1, D clamped to 64, out=0, cnt cleared. Then pulse rst low mid-stream -> all outputs 0 on the next cycle.
